alu_op_sequencer: RTL

- Command front-end directly upstream of the combinational 32-bit ALU (A, B, cin, opsel[2:0], mode, output1, cout).
- Accepts one operation at a time over a valid/ready command port, checks that the opcode is legal, and drives registered operands into the ALU.
- Holds those operands for a fixed settle window, then captures output1/cout with derived flags and presents them on a valid/ready response port.
- Supports chaining, where the previous result replaces operand A.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_cmd_decode.sv | 28 ++
 rtl/alu_op_sequencer.sv | 121 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: ALU mode and opcode
// encodings plus the sequencer state type.
package alu_pkg;

   // ALU mode select
   localparam logic MODE_ARITH = 1'b0;
   localparam logic MODE_LOGIC = 1'b1;

   // Arithmetic-mode opcodes
   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SBB  = 3'b001;
   localparam logic [2:0] OP_MOV  = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_INC  = 3'b100;
   localparam logic [2:0] OP_DEC  = 3'b101;
   localparam logic [2:0] OP_ADDI = 3'b110;

   // Logic-mode opcodes
   localparam logic [2:0] OP_AND  = 3'b000;
   localparam logic [2:0] OP_OR   = 3'b001;
   localparam logic [2:0] OP_XOR  = 3'b010;
   localparam logic [2:0] OP_NOT  = 3'b011;
   localparam logic [2:0] OP_SHL  = 3'b101;

   // Sequencer states
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      RESP   = 2'd2
   } seq_state_t;

endpackage

// File: rtl/alu_cmd_decode.sv
// Combinational legality check of a {mode, opsel} command pair.
module alu_cmd_decode (
   input  logic       mode,
   input  logic [2:0] opsel,
   output logic       legal
);
   import alu_pkg::*;

   // Flag the opcodes the downstream ALU actually implements
   always_comb begin
      // NOTE: default assigned first so every path drives legal and no latch is inferred.
      legal = 1'b0;
      if (mode == MODE_ARITH) begin
         case (opsel)
            OP_ADD, OP_SBB, OP_MOV, OP_SUB,
            OP_INC, OP_DEC, OP_ADDI: legal = 1'b1;
            default:                 legal = 1'b0;
         endcase
      end else begin
         case (opsel)
            OP_AND, OP_OR, OP_XOR,
            OP_NOT, OP_SHL:          legal = 1'b1;
            default:                 legal = 1'b0;
         endcase
      end
   end

endmodule

// File: rtl/alu_op_sequencer.sv
// Command front-end for the combinational ALU: accepts one operation,
// drives registered operands, waits a settle window, captures the result
// with flags and hands it out over a valid/ready response port.
module alu_op_sequencer #(
   parameter int WIDTH         = 32,
   parameter int SETTLE_CYCLES = 1,
   parameter int CNT_W         = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [WIDTH-1:0] cmd_a,
   input  logic [WIDTH-1:0] cmd_b,
   input  logic             cmd_cin,
   input  logic             cmd_mode,
   input  logic [2:0]       cmd_opsel,
   input  logic             cmd_chain,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic             alu_cin,
   output logic             alu_mode,
   output logic [2:0]       alu_opsel,
   input  logic [WIDTH-1:0] alu_output1,
   input  logic             alu_cout,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_cout,
   output logic             rsp_zero,
   output logic             rsp_neg,
   output logic             rsp_err,
   output logic [CNT_W-1:0] op_count
);
   import alu_pkg::*;

   // Settle counter is 4 bits wide, enough for a window of up to 15 clocks
   localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

   seq_state_t       state;
   logic [3:0]       cnt;
   logic [WIDTH-1:0] last_result;
   logic             cmd_legal;

   alu_cmd_decode u_decode (
      .mode  (cmd_mode),
      .opsel (cmd_opsel),
      .legal (cmd_legal)
   );

   // Handshake flags come straight from the state register
   assign cmd_ready = (state == IDLE);
   assign rsp_valid = (state == RESP);

   // Sequencer: accept, settle, capture, then hold the response until taken
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: non-blocking assignments throughout so every register updates from pre-edge values.
         state       <= IDLE;
         cnt         <= '0;
         last_result <= '0;
         alu_a       <= '0;
         alu_b       <= '0;
         alu_cin     <= 1'b0;
         alu_mode    <= 1'b0;
         alu_opsel   <= '0;
         rsp_data    <= '0;
         rsp_cout    <= 1'b0;
         rsp_zero    <= 1'b0;
         rsp_neg     <= 1'b0;
         rsp_err     <= 1'b0;
         op_count    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  if (cmd_legal) begin
                     alu_a     <= cmd_chain ? last_result : cmd_a;
                     alu_b     <= cmd_b;
                     alu_cin   <= cmd_cin;
                     alu_mode  <= cmd_mode;
                     alu_opsel <= cmd_opsel;
                     cnt       <= SETTLE_INIT;
                     state     <= SETTLE;
                  end else begin
                     // Illegal opcode: leave the ALU drive untouched, report an error
                     rsp_data  <= '0;
                     rsp_cout  <= 1'b0;
                     rsp_zero  <= 1'b0;
                     rsp_neg   <= 1'b0;
                     rsp_err   <= 1'b1;
                     state     <= RESP;
                  end
               end
            end
            SETTLE: begin
               if (cnt == 4'd1) begin
                  rsp_data    <= alu_output1;
                  rsp_cout    <= alu_mode ? 1'b0 : alu_cout;
                  rsp_zero    <= (alu_output1 == '0);
                  rsp_neg     <= alu_output1[WIDTH-1];
                  rsp_err     <= 1'b0;
                  last_result <= alu_output1;
                  cnt         <= '0;
                  state       <= RESP;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  op_count <= op_count + CNT_W'(1);
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
